sseg_scan_decoder: RTL and testbench
====================================

// Module: sseg_scan_decoder
// PURPOSE
//  Receive-side counterpart of the multiplexed seven-segment driver. Samples
//  the time-multiplexed segment/enable bus, captures the pattern of each digit
//  once its enable has settled, debounces the pattern across scan frames, and
//  decodes it back to a 4-bit hex value plus a decimal-point bit per digit.
//  Used for on-board loopback self-test and for the display-checking bench.
// PARAMETERS
//  N_DIGITS       3   number of multiplexed digits (width of en)
//  ACTIVE_LOW     1   1: ss and en are active-low on the bus; 0: active-high
//  SETTLE_CYCLES  4   consecutive cycles en must hold one digit before capture (>=1)
//  STABLE_FRAMES  2   identical captures of a digit needed before its output updates (>=1)
// PORTS
//  clk        in   1            system clock; all logic on rising edge
//  reset      in   1            synchronous, active-high reset
//  ss         in   8            segment bus: ss[6:0]=g..a, ss[7]=dp
//  en         in   N_DIGITS     digit enables; en[i] selects digit i (0 = rightmost)
//  hex        out  4*N_DIGITS   decoded value; digit i at hex[4*i+3:4*i]
//  dp         out  N_DIGITS     decoded decimal point per digit
//  dig_valid  out  N_DIGITS     1 = last accepted pattern of digit i is a legal hex glyph
//  updated    out  1            1-cycle pulse when any hex/dp/dig_valid value changes
//  frame_tick out  1            1-cycle pulse on each capture of digit N_DIGITS-1
//  en_err     out  1            1-cycle pulse when >1 enable asserted (first cycle of event)
// BEHAVIOUR
//  Reset: hex, dp, dig_valid, updated, frame_tick, en_err = 0; all candidate
//   patterns, stability and settle counters cleared; input registers cleared.
//  Input stage: ss and en registered once; if ACTIVE_LOW both are inverted so all
//   internal logic is active-high. Every latency below counts from this register.
//  Enable classes (registered en): NONE (all 0), ONE (exactly one bit set, index k),
//   MULTI (>1 bit). NONE and MULTI never capture and clear the settle counter.
//   en_err pulses on the first cycle of each MULTI run only.
//  Settle: counter counts cycles en stays ONE at the same k; any change of k or
//   class restarts it. On the cycle the count reaches SETTLE_CYCLES, ss is captured
//   for digit k exactly once; further cycles at the same k do not recapture until
//   en leaves digit k and returns.
//  Stability per digit: on capture, if pattern equals candidate[k], stab[k] increments
//   (saturating at STABLE_FRAMES); else candidate[k] <= pattern, stab[k] <= 1.
//   When stab[k] reaches STABLE_FRAMES (including the capture setting it to 1 when
//   STABLE_FRAMES=1) the pattern is accepted. Output registers update the cycle after
//   the accepting capture; updated pulses that same cycle only if a value changed.
//  Decode (active-high gfedcba): 3F=0 06=1 5B=2 4F=3 66=4 6D=5 7D=6 07=7 7F=8 6F=9
//   77=A 7C=b 39=C 5E=d 79=E 71=F. Any other 7-bit pattern (incl. blank 00):
//   dig_valid[k]=0, hex digit k=0. dp[k]=ss[7] regardless of glyph validity.
//  frame_tick pulses the cycle the capture of digit N_DIGITS-1 occurs (not gated on
//   stability). Digit order on the bus is not assumed; any scan order works.
//  Simultaneous: capture and en_err cannot coincide (classes exclusive). reset wins
//   over every other event; reset mid-digit discards partial settle/stability state.
//  Total latency, steady bus: pattern visible on hex after 1 + SETTLE_CYCLES + 1
//   cycles of the digit's STABLE_FRAMES-th qualifying scan.
// TESTING
//  1 Reset: hold reset 3 cycles with random bus -> all outputs 0, no pulses.
//  2 Loopback "123" (ACTIVE_LOW=1, en scans 110,101,011, 16 cycles each) -> after 2nd
//    frame hex=12'h123, dig_valid=3'b111, updated pulses once per digit update, dp=0.
//  3 Glitch: digit 1 shows 7F for 3 cycles (< SETTLE_CYCLES) then 06 -> captures 06 only.
//  4 Debounce: digit 0 alternates 3F/06 each frame -> hex[3:0] never changes, updated silent.
//  5 Illegal: ss=~8'h80 on digit 2 for 2 frames -> dig_valid[2]=0, hex[11:8]=0, dp[2]=1.
//  6 en=3'b000 for 2 cycles -> en_err pulse once, no capture; reset asserted
//    mid-settle -> outputs cleared, next capture needs full settle + STABLE_FRAMES.

Source files
------------

// File: rtl/sseg_scan_decoder.sv
// Receive side of the multiplexed seven-segment bus: waits for each digit enable
// to settle, captures the pattern, debounces it across frames and decodes it.
module sseg_scan_decoder #(
    parameter int N_DIGITS      = 3,
    parameter int ACTIVE_LOW    = 1,
    parameter int SETTLE_CYCLES = 4,
    parameter int STABLE_FRAMES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            ss,
    input  logic [N_DIGITS-1:0]   en,
    output logic [4*N_DIGITS-1:0] hex,
    output logic [N_DIGITS-1:0]   dp,
    output logic [N_DIGITS-1:0]   dig_valid,
    output logic                  updated,
    output logic                  frame_tick,
    output logic                  en_err
);
    localparam int KW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int SW = $clog2(STABLE_FRAMES + 1);
    localparam logic [CW-1:0]       SETTLE_MAX = CW'(SETTLE_CYCLES);
    localparam logic [SW-1:0]       STAB_MAX   = SW'(STABLE_FRAMES);
    localparam logic [KW-1:0]       LAST_K     = KW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] EN_LSB     = N_DIGITS'(1);

    typedef enum logic [1:0] {EN_NONE, EN_ONE, EN_MULTI} en_class_t;

    logic [7:0]            ss_r;
    logic [N_DIGITS-1:0]   en_r;
    en_class_t             cls;
    logic [KW-1:0]         k;
    logic                  last_one;
    logic [KW-1:0]         last_k;
    logic                  multi_d;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  same, capture;
    logic [7:0]            cand [N_DIGITS];
    logic [SW-1:0]         stab [N_DIGITS];
    logic [SW-1:0]         stab_nx;
    logic                  acc_v;
    logic [KW-1:0]         acc_k;
    logic [7:0]            acc_pat;
    logic [4:0]            glyph;
    logic [4*N_DIGITS-1:0] hex_nx;
    logic [N_DIGITS-1:0]   dp_nx, valid_nx;

    // Returns {legal, hex nibble}; illegal glyphs decode to {0, 0}.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   decode = 5'h10;
            7'h06:   decode = 5'h11;
            7'h5B:   decode = 5'h12;
            7'h4F:   decode = 5'h13;
            7'h66:   decode = 5'h14;
            7'h6D:   decode = 5'h15;
            7'h7D:   decode = 5'h16;
            7'h07:   decode = 5'h17;
            7'h7F:   decode = 5'h18;
            7'h6F:   decode = 5'h19;
            7'h77:   decode = 5'h1A;
            7'h7C:   decode = 5'h1B;
            7'h39:   decode = 5'h1C;
            7'h5E:   decode = 5'h1D;
            7'h79:   decode = 5'h1E;
            7'h71:   decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    always_comb begin : classify
        k = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++)
            if (en_r[i]) k = KW'(i);
        if (en_r == '0)
            cls = EN_NONE;
        else if ((en_r & (en_r - EN_LSB)) == '0)
            cls = EN_ONE;
        else
            cls = EN_MULTI;
    end

    // Counter saturates at SETTLE_MAX so a long dwell captures exactly once.
    always_comb begin : settle
        same    = last_one && (cls == EN_ONE) && (k == last_k);
        cnt_nx  = '0;
        if (cls == EN_ONE)
            cnt_nx = !same ? CW'(1) : ((cnt == SETTLE_MAX) ? cnt : cnt + CW'(1));
        capture = (cls == EN_ONE) && (cnt_nx == SETTLE_MAX) && !(same && (cnt == SETTLE_MAX));
        stab_nx = SW'(1);
        if (cand[k] == ss_r)
            stab_nx = (stab[k] == STAB_MAX) ? stab[k] : stab[k] + SW'(1);
    end

    always_comb begin : decode_out
        hex_nx   = hex;
        dp_nx    = dp;
        valid_nx = dig_valid;
        glyph    = decode(acc_pat[6:0]);
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (acc_v && (acc_k == KW'(i))) begin
                hex_nx[4*i +: 4] = glyph[3:0];
                dp_nx[i]         = acc_pat[7];
                valid_nx[i]      = glyph[4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ss_r       <= '0;
            en_r       <= '0;
            last_one   <= 1'b0;
            last_k     <= '0;
            multi_d    <= 1'b0;
            cnt        <= '0;
            acc_v      <= 1'b0;
            acc_k      <= '0;
            acc_pat    <= '0;
            hex        <= '0;
            dp         <= '0;
            dig_valid  <= '0;
            updated    <= 1'b0;
            frame_tick <= 1'b0;
            en_err     <= 1'b0;
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                cand[i] <= '0;
                stab[i] <= '0;
            end
        end else begin
            ss_r       <= (ACTIVE_LOW != 0) ? ~ss : ss;
            en_r       <= (ACTIVE_LOW != 0) ? ~en : en;
            last_one   <= (cls == EN_ONE);
            last_k     <= k;
            multi_d    <= (cls == EN_MULTI);
            cnt        <= cnt_nx;
            en_err     <= (cls == EN_MULTI) && !multi_d;
            frame_tick <= capture && (k == LAST_K);
            if (capture) begin
                cand[k] <= ss_r;
                stab[k] <= stab_nx;
            end
            // Acceptance is staged one cycle so outputs follow the accepting capture.
            acc_v      <= capture && (stab_nx == STAB_MAX);
            acc_k      <= k;
            acc_pat    <= ss_r;
            hex        <= hex_nx;
            dp         <= dp_nx;
            dig_valid  <= valid_nx;
            updated    <= acc_v && ({hex_nx, dp_nx, valid_nx} != {hex, dp, dig_valid});
        end
    end
endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: a behavioural model queues every expected
// output update with its cycle; a monitor pops and compares on each updated pulse.
module tb_sseg_scan_decoder;
    localparam int ND     = 3;
    localparam int SETTLE = 4;
    localparam int STABLE = 2;

    typedef struct {
        logic [11:0] hex;
        logic [2:0]  dp;
        logic [2:0]  val;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ss;
    logic [2:0]  en;
    logic [11:0] hex;
    logic [2:0]  dp, dig_valid;
    logic        updated, frame_tick, en_err;

    int checks = 0, failures = 0;
    int cyc = 0, ticks = 0, errs = 0, exp_ticks = 0, exp_err = 0;
    exp_t sb[$];

    logic [7:0]  mcand [ND];
    int          mstab [ND];
    logic [11:0] mhex;
    logic [2:0]  mdp, mval;
    logic [6:0]  glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    sseg_scan_decoder #(
        .N_DIGITS(ND), .ACTIVE_LOW(1), .SETTLE_CYCLES(SETTLE), .STABLE_FRAMES(STABLE)
    ) dut (
        .clk(clk), .reset(reset), .ss(ss), .en(en), .hex(hex), .dp(dp),
        .dig_valid(dig_valid), .updated(updated), .frame_tick(frame_tick), .en_err(en_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (frame_tick) ticks++;
        if (en_err) errs++;
        if (updated) begin
            if (sb.size() == 0) begin
                chk("spurious_updated", 32'(updated), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("upd_hex", 32'(hex), 32'(e.hex));
                chk("upd_dp", 32'(dp), 32'(e.dp));
                chk("upd_valid", 32'(dig_valid), 32'(e.val));
                chk("upd_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            mcand[i] = '0;
            mstab[i] = 0;
        end
        mhex = '0;
        mdp  = '0;
        mval = '0;
    endtask

    task automatic model_capture(input int d, input logic [7:0] p, input int ucyc);
        logic [3:0]  h;
        logic        v;
        logic [11:0] nh;
        logic [2:0]  nd, nv;
        exp_t        e;
        if (d == ND - 1) exp_ticks++;
        if (p == mcand[d]) begin
            if (mstab[d] < STABLE) mstab[d]++;
        end else begin
            mcand[d] = p;
            mstab[d] = 1;
        end
        if (mstab[d] == STABLE) begin
            h = 4'h0;
            v = 1'b0;
            for (int g = 0; g < 16; g++)
                if (glyphs[g] == p[6:0]) begin
                    h = 4'(g);
                    v = 1'b1;
                end
            nh = mhex;
            nd = mdp;
            nv = mval;
            nh[4*d +: 4] = h;
            nd[d] = p[7];
            nv[d] = v;
            if ({nh, nd, nv} != {mhex, mdp, mval}) begin
                e.hex = nh; e.dp = nd; e.val = nv; e.cyc = ucyc;
                sb.push_back(e);
            end
            mhex = nh;
            mdp  = nd;
            mval = nv;
        end
    endtask

    // Enable digit d; pattern pa for na cycles then pb for nb cycles (internal polarity).
    task automatic scan2(input int d, input logic [7:0] pa, input int na,
                         input logic [7:0] pb, input int nb);
        int start;
        start = cyc;
        if (na >= SETTLE)
            model_capture(d, pa, start + SETTLE + 2);
        else if (na + nb >= SETTLE)
            model_capture(d, pb, start + SETTLE + 2);
        ss = ~pa;
        en = ~(3'b001 << d);
        repeat (na) @(posedge clk);
        #1;
        if (nb > 0) begin
            ss = ~pb;
            repeat (nb) @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
        scan2(0, p0, 16, p0, 0);
        scan2(1, p1, 16, p1, 0);
        scan2(2, p2, 16, p2, 0);
    endtask

    task automatic idle(input int n);
        ss = 8'hFF;
        en = 3'b111;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        ss = 8'($urandom);
        en = 3'($urandom);
        @(posedge clk);
        #1;
        // 1: reset with a random bus
        for (int i = 0; i < 3; i++) begin
            ss = 8'($urandom);
            en = 3'($urandom);
            @(negedge clk);
            chk("reset_outputs", 32'({hex, dp, dig_valid, updated, frame_tick, en_err}), 32'd0);
            @(posedge clk);
            #1;
        end
        ss = 8'hFF;
        en = 3'b111;
        reset = 1'b0;
        idle(4);
        chk("post_reset_hex", 32'(hex), 32'd0);

        // 2: loopback "123"
        frame(8'h4F, 8'h5B, 8'h06);
        chk("frame1_no_update", 32'(hex), 32'd0);
        frame(8'h4F, 8'h5B, 8'h06);
        frame(8'h4F, 8'h5B, 8'h06);
        idle(4);
        chk("loop_hex", 32'(hex), 32'h123);
        chk("loop_valid", 32'(dig_valid), 32'b111);
        chk("loop_dp", 32'(dp), 32'd0);
        chk("loop_sb_empty", 32'(sb.size()), 32'd0);

        // 3: short 7F glitch on digit 1 before settling on 06
        for (int f = 0; f < 2; f++) begin
            scan2(0, 8'h4F, 16, 8'h4F, 0);
            scan2(1, 8'h7F, 3, 8'h06, 13);
            scan2(2, 8'h06, 16, 8'h06, 0);
        end
        idle(4);
        chk("glitch_hex", 32'(hex), 32'h113);

        // 4: digit 0 flips every frame and must never be accepted
        for (int f = 0; f < 4; f++)
            frame((f % 2 == 0) ? 8'h3F : 8'h06, 8'h06, 8'h06);
        idle(4);
        chk("debounce_hex", 32'(hex), 32'h113);

        // 5: blank glyph with decimal point on digit 2
        frame(8'h4F, 8'h06, 8'h80);
        frame(8'h4F, 8'h06, 8'h80);
        idle(4);
        chk("illegal_hex", 32'(hex), 32'h013);
        chk("illegal_valid", 32'(dig_valid), 32'b011);
        chk("illegal_dp", 32'(dp), 32'b100);

        // 6: all enables on the bus, then reset in the middle of a settle
        ss = 8'hFF;
        en = 3'b000;
        exp_err++;
        repeat (2) @(posedge clk);
        #1;
        idle(4);
        chk("en_err_count", 32'(errs), 32'(exp_err));
        chk("multi_no_tick", 32'(ticks), 32'(exp_ticks));
        chk("pre_reset_sb", 32'(sb.size()), 32'd0);
        ss = ~8'h66;
        en = 3'b110;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_outputs", 32'({hex, dp, dig_valid}), 32'd0);
        reset = 1'b0;
        model_reset();
        scan2(0, 8'h66, 16, 8'h66, 0);
        scan2(1, 8'h06, 16, 8'h06, 0);
        chk("after_reset_first_frame", 32'(hex), 32'd0);
        scan2(0, 8'h66, 16, 8'h66, 0);
        scan2(1, 8'h06, 16, 8'h06, 0);
        idle(4);
        chk("after_reset_hex", 32'(hex), 32'h014);
        chk("after_reset_valid", 32'(dig_valid), 32'b011);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("frame_ticks", 32'(ticks), 32'(exp_ticks));
        chk("en_err_final", 32'(errs), 32'(exp_err));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
